// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory_interface port between a line-fill
// reader (requester 0) and a writeback buffer (requester 1).
// Optional WAIT-state timeout is enabled with `define ARB_TIMEOUT_EN.
module mem_req_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rd_wrt0,
  input  logic              rd_wrt1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [1:0]        gnt,
  output logic              mem_enable,
  output logic              mem_rd_wrt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_done_q;
  logic [1:0]          r_gnt;
  logic                r_mem_enable;
  logic                r_mem_rd_wrt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_data_out;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack0;
  logic                r_ack1;

  logic                w_done_rise;
  logic                w_any_req;
  logic                w_pick1;

  // Only an edge on mem_done counts, so a level left over from the previous
  // transaction can never complete the next one.
  assign w_done_rise = mem_done & ~r_done_q;
  assign w_any_req   = req0 | req1;
  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign w_pick1     = req1 & (~req0 | ~r_last_grant);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // NOTE: state registers use non-blocking assignments so every branch sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        ISSUE:   r_cnt <= '0;
        WAIT:    begin
          r_cnt <= r_cnt + 1'b1;
          r_err <= ~w_done_rise & (r_cnt == CNT_W'(TIMEOUT - 1));
        end
        default: r_err <= 1'b0;
      endcase
    end
  end

  logic w_timeout;
  assign w_timeout = (r_state == WAIT) & ~w_done_rise & (r_cnt == CNT_W'(TIMEOUT - 1));
  assign err       = r_err;
`else
  logic w_timeout;
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_last_grant   <= 1'b1;
      r_done_q       <= 1'b0;
      r_gnt          <= 2'b00;
      r_mem_enable   <= 1'b0;
      r_mem_rd_wrt   <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data_out <= '0;
      r_rdata        <= '0;
      r_ack0         <= 1'b0;
      r_ack1         <= 1'b0;
    end else begin
      r_done_q <= mem_done;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_mem_rd_wrt   <= w_pick1 ? rd_wrt1 : rd_wrt0;
            r_mem_addr     <= w_pick1 ? addr1   : addr0;
            r_mem_data_out <= w_pick1 ? wdata1  : wdata0;
            r_gnt          <= w_pick1 ? 2'b10   : 2'b01;
            r_last_grant   <= w_pick1;
            r_mem_enable   <= 1'b1;
            r_state        <= ISSUE;
          end
        end
        ISSUE: begin
          r_mem_enable <= 1'b0;
          r_state      <= WAIT;
        end
        WAIT: begin
          if (w_done_rise) begin
            if (r_mem_rd_wrt) r_rdata <= mem_data_in;
            r_ack0  <= r_gnt[0];
            r_ack1  <= r_gnt[1];
            r_state <= RESP;
          end else if (w_timeout) begin
            r_ack0  <= r_gnt[0];
            r_ack1  <= r_gnt[1];
            r_state <= RESP;
          end
        end
        RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_gnt   <= 2'b00;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign rdata        = r_rdata;
  assign busy         = (r_state != IDLE);
  assign gnt          = r_gnt;
  assign mem_enable   = r_mem_enable;
  assign mem_rd_wrt   = r_mem_rd_wrt;
  assign mem_addr     = r_mem_addr;
  assign mem_data_out = r_mem_data_out;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: requester queues, a memory model,
// and a scoreboard of expected issues and acks in service order.
module tb_mem_req_arbiter;
  localparam int AW = 14;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          rd_wrt0 = 1'b0, rd_wrt1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err, busy, mem_enable, mem_rd_wrt;
  logic [DW-1:0] rdata, mem_data_out, mem_data_in;
  logic [1:0]    gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_done;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst_n),
    .req0(req0), .req1(req1), .rd_wrt0(rd_wrt0), .rd_wrt1(rd_wrt1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy), .gnt(gnt),
    .mem_enable(mem_enable), .mem_rd_wrt(mem_rd_wrt), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_done(mem_done)
  );

  typedef struct {int id; logic rd; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_t;
  typedef struct {int id; logic [DW-1:0] rdata; logic err;} ack_t;
  typedef struct {
    logic v0, v1, rd0, rd1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int first;
    int delay;
  } vec_t;

  req_t rq0[$], rq1[$], iss_q[$];
  ack_t ack_q[$];
  int n_checks = 0, n_pass = 0, cyc = 0;
  logic [DW-1:0] exp_rdata = '0;
  logic prev_en = 1'b0;

  // Memory model: automatic done pulse mem_delay cycles after enable, or
  // manual control of done/data from the test sequences.
  logic auto_mem = 1'b1;
  int   mem_delay = 3;
  int   a_cnt = 0;
  logic a_done = 1'b0, man_done = 1'b0;
  logic [DW-1:0] a_data = '0, man_data = '0;
  assign mem_done    = auto_mem ? a_done : man_done;
  assign mem_data_in = auto_mem ? a_data : man_data;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return 64'h0123456789abcdef ^ ({50'd0, a} << 20);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_cnt  = 0;
      a_done = 1'b0;
    end else if (mem_enable) begin
      a_cnt  = mem_delay;
      a_done = 1'b0;
    end else if (a_cnt > 0) begin
      a_cnt--;
      if (a_cnt == 0) begin
        a_done = 1'b1;
        a_data = mem_fn(mem_addr);
      end
    end else a_done = 1'b0;
  end

  // Requesters hold req until their ack, then present the next queued entry.
  always @(negedge clk) begin
    if (req0 && ack0 && rq0.size() > 0) void'(rq0.pop_front());
    if (req1 && ack1 && rq1.size() > 0) void'(rq1.pop_front());
    if (rq0.size() > 0) begin
      req0 = 1'b1; rd_wrt0 = rq0[0].rd; addr0 = rq0[0].addr; wdata0 = rq0[0].wdata;
    end else req0 = 1'b0;
    if (rq1.size() > 0) begin
      req1 = 1'b1; rd_wrt1 = rq1[0].rd; addr1 = rq1[0].addr; wdata1 = rq1[0].wdata;
    end else req1 = 1'b0;
  end

  // Scoreboard: compare every enable pulse and every ack against the queues.
  always @(negedge clk) begin
    if (!rst_n) prev_en = 1'b0;
    else begin
      if (mem_enable) begin
        check("enable_one_cycle", prev_en, 0);
        if (iss_q.size() == 0) check("issue_expected", iss_q.size(), 1);
        else begin
          req_t e;
          e = iss_q.pop_front();
          check("issue_rd_wrt", mem_rd_wrt, e.rd);
          check("issue_addr", mem_addr, e.addr);
          check("issue_gnt", gnt, (e.id == 1) ? 2'b10 : 2'b01);
          if (!e.rd) check("issue_wdata", mem_data_out, e.wdata);
        end
      end
      prev_en = mem_enable;
      if (ack0 || ack1) begin
        check("ack_onehot", {ack0, ack1}, (ack0 ? 2'b10 : 2'b01));
        if (ack_q.size() == 0) check("ack_expected", ack_q.size(), 1);
        else begin
          ack_t a;
          a = ack_q.pop_front();
          check("ack_id", ack1 ? 1 : 0, a.id);
          check("ack_rdata", rdata, a.rdata);
          check("ack_err", err, a.err);
        end
      end
    end
  end

  task automatic send(input int id, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.id = id; r.rd = rd; r.addr = a; r.wdata = d;
    if (id == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic expect_txn(input int id, input logic rd, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic e_err);
    req_t r;
    ack_t k;
    r.id = id; r.rd = rd; r.addr = a; r.wdata = d;
    iss_q.push_back(r);
    if (rd && !e_err) exp_rdata = mem_fn(a);
    k.id = id; k.rdata = exp_rdata; k.err = e_err;
    ack_q.push_back(k);
  endtask

  task automatic flush();
    rq0.delete(); rq1.delete(); iss_q.delete(); ack_q.delete();
    exp_rdata = '0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ack_q.size() == 0 && iss_q.size() == 0) return;
    end
    check("drain_timeout", ack_q.size() + iss_q.size(), 0);
  endtask

  task automatic wait_enable(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_enable) return;
    end
    check("enable_timeout", mem_enable, 1);
  endtask

  vec_t vt[8];
  int   t0, t1;

  initial begin
    vt[0] = '{1, 1, 0, 1, 14'h0010, 14'h0020, 64'hA5A5A5A5A5A5A5A5, 64'h0, 0, 3};
    vt[1] = '{1, 1, 1, 0, 14'h0011, 14'h0021, 64'h0, 64'h5A5A5A5A5A5A5A5A, 0, 2};
    vt[2] = '{1, 0, 1, 0, 14'h0000, 14'h0000, 64'h0, 64'h0, 0, 3};
    vt[3] = '{0, 1, 0, 0, 14'h0000, 14'h03FF, 64'h0, 64'hDEADBEEF00C0FFEE, 1, 1};
    vt[4] = '{0, 1, 0, 1, 14'h0000, 14'h1234, 64'h0, 64'h0, 1, 4};
    vt[5] = '{1, 1, 1, 1, 14'h00AA, 14'h00BB, 64'h0, 64'h0, 0, 1};
    vt[6] = '{1, 0, 0, 0, 14'h3FFF, 14'h0000, 64'hFFFF0000FFFF0000, 64'h0, 0, 2};
    vt[7] = '{1, 1, 0, 0, 14'h0101, 14'h0202, 64'h1111, 64'h2222, 1, 3};

    // Reset held with a pending request: nothing moves until release.
    send(0, 1, 14'h0000, 64'h0);
    expect_txn(0, 1, 14'h0000, 64'h0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_enable", mem_enable, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("enable_after_release", mem_enable, 1);
    @(posedge clk); #1;
    check("enable_drops", mem_enable, 0);
    wait_drain(50);

    // Fresh reset so requester 0 wins the first tie.
    @(negedge clk); rst_n = 1'b0; flush();
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      mem_delay = vt[i].delay;
      if (vt[i].v0) send(0, vt[i].rd0, vt[i].a0, vt[i].d0);
      if (vt[i].v1) send(1, vt[i].rd1, vt[i].a1, vt[i].d1);
      for (int k = 0; k < 2; k++) begin
        int id;
        id = (k == 0) ? vt[i].first : 1 - vt[i].first;
        if (id == 0 && vt[i].v0) expect_txn(0, vt[i].rd0, vt[i].a0, vt[i].d0, 0);
        if (id == 1 && vt[i].v1) expect_txn(1, vt[i].rd1, vt[i].a1, vt[i].d1, 0);
      end
      wait_drain(100);
    end

    // Address changes during WAIT must not reach mem_addr.
    mem_delay = 8;
    send(1, 1, 14'h0020, 64'h0);
    expect_txn(1, 1, 14'h0020, 64'h0, 0);
    wait_enable(20);
    @(negedge clk);
    begin
      req_t tmp;
      tmp = rq1[0];
      tmp.addr = 14'h3FFF;
      rq1[0] = tmp;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (ack1) break;
      check("latch_addr_stable", mem_addr, 14'h0020);
    end
    wait_drain(20);

    // A done level already high at enable must not complete the transaction.
    auto_mem = 1'b0;
    man_done = 1'b1;
    man_data = mem_fn(14'h0055);
    send(0, 1, 14'h0055, 64'h0);
    expect_txn(0, 1, 14'h0055, 64'h0, 0);
    wait_enable(20);
    repeat (6) begin
      @(negedge clk);
      check("stale_done_no_ack", ack0, 0);
    end
    man_done = 1'b0;
    @(negedge clk); man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    wait_drain(20);

    // Reset in WAIT drops the transaction; the next one completes normally.
    auto_mem  = 1'b1;
    mem_delay = 20;
    send(1, 1, 14'h0066, 64'h0);
    expect_txn(1, 1, 14'h0066, 64'h0, 0);
    wait_enable(20);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_wait_busy", busy, 0);
    check("rst_wait_gnt", gnt, 0);
    check("rst_wait_addr", mem_addr, 0);
    check("rst_wait_rdata", rdata, 0);
    flush();
    @(negedge clk); rst_n = 1'b1;
    mem_delay = 2;
    send(1, 0, 14'h0077, 64'hCAFEF00DCAFEF00D);
    expect_txn(1, 0, 14'h0077, 64'hCAFEF00DCAFEF00D, 0);
    wait_drain(40);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: ack0 and err together 9 cycles after enable.
    auto_mem = 1'b0;
    man_done = 1'b0;
    send(0, 1, 14'h0044, 64'h0);
    expect_txn(0, 1, 14'h0044, 64'h0, 1);
    wait_enable(20);
    t0 = cyc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack0) break;
    end
    t1 = cyc;
    check("timeout_latency", t1 - t0, 9);
    wait_drain(10);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
